// File: rtl/shift_seq_pkg.sv
// Shared opcodes and FSM encoding for the shift register sequencer.
// Imported by the sequencer top level.
package shift_seq_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/shift_reg_lr.sv
// Loadable left/right shift register with zero fill.
// Load has priority over shift.
module shift_reg_lr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic             shift_left_right,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Register update: load, shift left, shift right, or hold
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= data_in;
    end else if (shift_en && shift_left_right) begin
      r_q <= {r_q[WIDTH-2:0], 1'b0};
    end else if (shift_en) begin
      r_q <= {1'b0, r_q[WIDTH-1:1]};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command sequencer driving a shift register.
// One command in flight; each ends with a one-cycle done pulse.
module shift_reg_sequencer
  import shift_seq_pkg::*;
#(
  parameter int REG_WIDTH = 8,
  parameter int CNT_W     = $clog2(REG_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CNT_W-1:0]     cmd_count,
  input  logic [REG_WIDTH-1:0] cmd_data,
  output logic                 load,
  output logic                 shift_en,
  output logic                 shift_left_right,
  output logic [REG_WIDTH-1:0] data_in,
  output logic [REG_WIDTH-1:0] q_out,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(REG_WIDTH);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [REG_WIDTH-1:0] r_data;
  logic                 r_load;
  logic                 r_shift_en;
  logic                 r_dir;
  logic                 r_done;
  logic [CNT_W-1:0]     w_clamp;

  assign w_clamp = (cmd_count > LP_MAX) ? LP_MAX : cmd_count;

  // Sequencer FSM with registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_data     <= '0;
      r_load     <= 1'b0;
      r_shift_en <= 1'b0;
      r_dir      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_data <= cmd_data;
            if (cmd_op == OP_LOAD) begin
              r_state <= ST_LOAD;
              r_load  <= 1'b1;
            end else if ((cmd_op == OP_SHL ||
                          cmd_op == OP_SHR) &&
                         w_clamp != '0) begin
              r_state    <= ST_SHIFT;
              r_shift_en <= 1'b1;
              r_dir      <= (cmd_op == OP_SHL);
              r_cnt      <= w_clamp;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          r_load  <= 1'b0;
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_SHIFT: begin
          if (r_cnt == LP_ONE) begin
            r_shift_en <= 1'b0;
            r_dir      <= 1'b0;
            r_cnt      <= '0;
            r_state    <= ST_DONE;
            r_done     <= 1'b1;
          end else begin
            r_cnt <= r_cnt - LP_ONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready        = (r_state == ST_IDLE) && !reset;
  assign busy             = (r_state != ST_IDLE);
  assign load             = r_load;
  assign shift_en         = r_shift_en;
  assign shift_left_right = r_dir;
  assign done             = r_done;
  assign data_in          = r_load ? r_data : '0;

  shift_reg_lr #(
    .WIDTH(REG_WIDTH)
  ) u_reg (
    .clk              (clk),
    .reset            (reset),
    .load             (load),
    .shift_en         (shift_en),
    .shift_left_right (shift_left_right),
    .data_in          (data_in),
    .q                (q_out)
  );

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer, REG_WIDTH = 8.
// Expected results queue at issue, checked at each done pulse.
module tb_shift_reg_sequencer;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b11;
  logic [CW-1:0] cmd_count = '0;
  logic [W-1:0]  cmd_data = '0;
  logic          load;
  logic          shift_en;
  logic          shift_left_right;
  logic [W-1:0]  data_in;
  logic [W-1:0]  q_out;
  logic          busy;
  logic          done;

  typedef struct {
    logic [W-1:0] q;
    int           nl;
    int           ns;
    logic         dir;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] model_q = '0;
  int           n_load = 0;
  int           n_shift = 0;
  logic         seen_dir = 1'b0;

  always #5 clk = ~clk;

  shift_reg_sequencer #(
    .REG_WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_count        (cmd_count),
    .cmd_data         (cmd_data),
    .load             (load),
    .shift_en         (shift_en),
    .shift_left_right (shift_left_right),
    .data_in          (data_in),
    .q_out            (q_out),
    .busy             (busy),
    .done             (done)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Per-cycle protocol checks and scoreboard pop on done
  always @(negedge clk) begin
    if (reset) begin
      n_load   = 0;
      n_shift  = 0;
      seen_dir = 1'b0;
    end else begin
      if (load || shift_en)
        check("excl", {31'd0, load & shift_en}, 32'd0);
      if (!load) check("din_idle", 32'(data_in), 32'd0);
      if (!shift_en)
        check("dir_idle", {31'd0, shift_left_right}, 32'd0);
      if (load) n_load++;
      if (shift_en) begin
        n_shift++;
        seen_dir = seen_dir | shift_left_right;
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("q_at_done", 32'(q_out), 32'(e.q));
          check("n_load", n_load, e.nl);
          check("n_shift", n_shift, e.ns);
          check("dir", {31'd0, seen_dir}, {31'd0, e.dir});
          check("busy_done", {31'd0, busy}, 32'd1);
        end
        n_load   = 0;
        n_shift  = 0;
        seen_dir = 1'b0;
      end
    end
  end

  function automatic exp_t predict(input logic [1:0] op,
                                   input int cnt,
                                   input logic [W-1:0] d);
    exp_t e;
    int   a;
    a = (cnt > W) ? W : cnt;
    e.nl  = 0;
    e.ns  = 0;
    e.dir = 1'b0;
    e.q   = model_q;
    case (op)
      2'b00: begin e.q = d; e.nl = 1; end
      2'b01: begin
        e.q = model_q << a; e.ns = a; e.dir = (a > 0);
      end
      2'b10: begin e.q = model_q >> a; e.ns = a; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic wait_done(input int exp_lat);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    check("done_seen", {31'd0, got}, 32'd1);
    check("latency", lat, exp_lat);
  endtask

  task automatic issue(input logic [1:0] op,
                       input int cnt,
                       input logic [W-1:0] d);
    exp_t e;
    bit   rdy;
    int   lat;
    rdy = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        rdy = 1'b1;
        break;
      end
    end
    check("ready_wait", {31'd0, rdy}, 32'd1);
    e = predict(op, cnt, d);
    sb.push_back(e);
    model_q   = e.q;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = CW'(cnt);
    cmd_data  = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = ~d;
    cmd_count = '1;
    lat = (op == 2'b00) ? 1 :
          (op == 2'b11) ? 0 :
          ((cnt > W) ? W : cnt);
    wait_done(lat);
  endtask

  initial begin
    exp_t e;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_q", 32'(q_out), 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_strobes", {30'd0, load, shift_en}, 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    issue(2'b00, 0, 8'hA5);
    issue(2'b01, 3, 8'h00);
    issue(2'b00, 0, 8'h81);
    issue(2'b10, 12, 8'hFF);
    issue(2'b00, 0, 8'h3C);
    issue(2'b01, 0, 8'h00);
    issue(2'b11, 5, 8'h12);
    issue(2'b00, 0, 8'hC6);
    issue(2'b10, 3, 8'h00);
    issue(2'b01, 8, 8'h00);
    issue(2'b00, 0, 8'h96);
    issue(2'b01, 9, 8'h00);

    // Reset after 2 of 5 shifts
    issue(2'b00, 0, 8'h1F);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_count = CW'(5);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_sh1", {31'd0, shift_en}, 32'd1);
    @(negedge clk);
    check("rst_mid_sh2", {31'd0, shift_en}, 32'd1);
    @(negedge clk);
    check("rst_mid_q", 32'(q_out), 32'h7C);
    reset = 1'b1;
    @(negedge clk);
    check("rst2_q", 32'(q_out), 32'd0);
    check("rst2_busy", {31'd0, busy}, 32'd0);
    check("rst2_strobes",
          {29'd0, load, shift_en, shift_left_right}, 32'd0);
    check("rst2_din", 32'(data_in), 32'd0);
    check("rst2_ready", {31'd0, cmd_ready}, 32'd0);
    reset = 1'b0;
    model_q = '0;
    #1;
    check("rst2_ready_rel", {31'd0, cmd_ready}, 32'd1);
    repeat (6) @(negedge clk);
    check("rst2_idle", {31'd0, busy}, 32'd0);

    // Valid held high, data changing while busy
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_count = '0;
    cmd_data  = 8'h5A;
    e = predict(2'b00, 0, 8'h5A);
    sb.push_back(e);
    model_q = e.q;
    @(posedge clk);
    #1;
    cmd_data = 8'hC3;
    @(negedge clk);
    check("hold_ready_ld", {31'd0, cmd_ready}, 32'd0);
    check("hold_din", 32'(data_in), 32'h5A);
    cmd_data = 8'h11;
    @(negedge clk);
    check("hold_ready_dn", {31'd0, cmd_ready}, 32'd0);
    check("hold_done", {31'd0, done}, 32'd1);
    cmd_data = 8'h77;
    e = predict(2'b00, 0, 8'h77);
    sb.push_back(e);
    model_q = e.q;
    @(negedge clk);
    check("hold_ready_idle", {31'd0, cmd_ready}, 32'd1);
    check("hold_q_idle", 32'(q_out), 32'h5A);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_done(1);

    issue(2'b10, 2, 8'h00);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_reg_sequencer.md
SHIFT_REG_SEQUENCER -- requirements
Module: shift_reg_sequencer

Interface
REQ-001 Parameter: REG_WIDTH, default 8, width of the shift register and data path (minimum 2).
REQ-002 Parameter: CNT_W, default $clog2(REG_WIDTH+1), width of the shift-count field.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_op  input  2  command opcode: 00 LOAD, 01 SHIFT_LEFT, 10 SHIFT_RIGHT, 11 NOP.
REQ-008 cmd_count  input  CNT_W  number of shifts for SHIFT ops.
REQ-009 cmd_data  input  REG_WIDTH  load value for LOAD.
REQ-010 load  output  1  register load strobe.
REQ-011 shift_en  output  1  register shift strobe.
REQ-012 shift_left_right  output  1  shift direction: 1 = left, 0 = right.
REQ-013 data_in  output  REG_WIDTH  value presented to the register.
REQ-014 q_out  output  REG_WIDTH  current register contents.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at command completion.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, SHIFT and DONE.
REQ-018 cmd_ready SHALL equal (state==IDLE) and SHALL be 0 while reset is high.
REQ-019 A command SHALL be accepted on a posedge where cmd_valid && cmd_ready; cmd_op, cmd_count and cmd_data SHALL be captured at that edge, and later changes to them SHALL be ignored.
REQ-020 Transitions from IDLE on accept: LOAD op -> LOAD; SHIFT op with count>0 -> SHIFT; SHIFT op with count=0 -> DONE; NOP -> DONE.
REQ-021 LOAD SHALL last exactly one cycle with load=1 and data_in=captured data, then go to DONE.
REQ-022 SHIFT SHALL assert shift_en=1 for exactly min(count, REG_WIDTH) consecutive cycles, with shift_left_right=1 for SHIFT_LEFT and 0 for SHIFT_RIGHT, then go to DONE.
REQ-023 A count greater than REG_WIDTH SHALL be clamped to REG_WIDTH.
REQ-024 DONE SHALL last one cycle with done=1, then go to IDLE; back-to-back commands are therefore separated by at least one DONE cycle.
REQ-025 load and shift_en SHALL never be high in the same cycle; both SHALL be 0 in IDLE and DONE.
REQ-026 The datapath SHALL update on posedge clk as follows:
- load=1: q <= data_in;
- else shift_en=1 and direction left: q <= {q[W-2:0], 0};
- else shift_en=1 and direction right: q <= {0, q[W-1:1]};
- otherwise q holds.
REQ-027 q_out SHALL hold the final command result in the cycle where done=1.
REQ-028 Latency from accept edge to done: LOAD 1 cycle; SHIFT N cycles (N = clamped count); count 0 or NOP 0 cycles, with done in the cycle after accept.
REQ-029 shift_left_right and data_in SHALL be 0 whenever they are not in use.

Reset
REQ-030 On reset: state=IDLE, q_out=0, shift counter=0, captured registers=0, and load, shift_en, shift_left_right, data_in, done and busy all 0.
REQ-031 Reset during LOAD or SHIFT SHALL abandon the command with no done pulse; cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-032 Package shift_seq_pkg SHALL hold the opcode constants (OP_LOAD, OP_SHL, OP_SHR, OP_NOP) and the FSM state encoding.
REQ-033 The register datapath SHALL be a separate sub-module, shift_reg_lr (clk, reset, load, shift_en, shift_left_right, data_in, q), instantiated once.

Verification (REG_WIDTH=8)
REQ-034 LOAD 8'hA5 -> load high for exactly 1 cycle; done 1 cycle later; q_out=8'hA5 while done=1.
REQ-035 LOAD 8'hA5, then SHIFT_LEFT count 3 -> shift_en high for 3 cycles with shift_left_right=1; q_out=8'h28 at done.
REQ-036 LOAD 8'h81, then SHIFT_RIGHT count 12 -> clamped to exactly 8 shift_en cycles; q_out=8'h00 at done.
REQ-037 SHIFT_LEFT count 0 after LOAD 8'h3C -> shift_en never asserted; done in the cycle after accept; q_out=8'h3C.
REQ-038 Reset asserted after 2 of 5 shifts -> outputs and q_out=0, no done pulse, cmd_ready=1 in the cycle after reset releases.
REQ-039 cmd_valid held high with cmd_data changing while busy -> cmd_ready=0 throughout; the in-flight result is unaffected; the next command is accepted only in IDLE after the DONE cycle.
